// File: rtl/ldl_sfifo_flags.sv
// ldl_sfifo_flags -- single-clock synchronous FIFO with programmable flags.
//
// Purpose:
//   Standard same-clock buffering primitive. Offers first-word-fall-through
//   (AHEAD=1) or registered-read (AHEAD=0) output, runtime almost-full /
//   almost-empty thresholds, sticky overflow/underflow error flags and a
//   synchronous flush.
//
// Parameters:
//   DWIDTH  data width in bits
//   AWIDTH  address width, DEPTH = 2**AWIDTH entries
//   AHEAD   1 = first-word-fall-through, 0 = data one cycle after re
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous reset, active-high (highest priority)
//   clear         synchronous flush, same effect as rst on FIFO state
//   we / din      write request and data
//   re / dout     read request and data
//   empty, full   occupancy == 0 / occupancy == DEPTH
//   af_thr        almost-full threshold  (almost_full  = count >= af_thr)
//   ae_thr        almost-empty threshold (almost_empty = count <= ae_thr)
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
//   count         current occupancy, 0..DEPTH
//   peak          high-water mark since last rst/clear
//
// Optional feature:
//   Define LDL_SFIFO_PEAK_EN to build the high-water-mark register; when it
//   is undefined the peak port is tied to 0.

module ldl_sfifo_flags #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4,
    parameter int AHEAD  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              we,
    input  logic [DWIDTH-1:0] din,
    input  logic              re,
    output logic [DWIDTH-1:0] dout,
    output logic              empty,
    output logic              full,
    input  logic [AWIDTH:0]   af_thr,
    input  logic [AWIDTH:0]   ae_thr,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow,
    output logic [AWIDTH:0]   count,
    output logic [AWIDTH:0]   peak
);

    localparam int DEPTH = 2 ** AWIDTH;
    // DEPTH expressed in the (AWIDTH+1)-bit count domain.
    localparam logic [AWIDTH:0] DEPTH_C = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] ONE_C   = {{AWIDTH{1'b0}}, 1'b1};

    logic [DWIDTH-1:0] mem [0:DEPTH-1];

    logic [AWIDTH-1:0] wr_ptr_reg;
    logic [AWIDTH-1:0] rd_ptr_reg;
    logic [AWIDTH:0]   count_reg;
    logic [AWIDTH:0]   count_next;
    logic              overflow_reg;
    logic              underflow_reg;

    logic flush;
    logic wr_en;
    logic rd_en;

    // rst and clear reset the same state; rst only wins in naming.
    assign flush = rst || clear;

    // Status flags come straight from the registered count.
    assign empty        = (count_reg == '0);
    assign full         = (count_reg == DEPTH_C);
    // af_thr == 0 is always satisfied; af_thr > DEPTH never is.
    assign almost_full  = (count_reg >= af_thr);
    assign almost_empty = (count_reg <= ae_thr);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // Acceptance is decided on registered state, so a read at full frees a
    // slot only for the following cycle, not for a write in the same cycle.
    assign wr_en = we && !full;
    assign rd_en = re && !empty;

    always_comb begin
        count_next = count_reg;
        case ({wr_en, rd_en})
            2'b10:   count_next = count_reg + ONE_C;
            2'b01:   count_next = count_reg - ONE_C;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg     <= count_next;
            overflow_reg  <= overflow_reg  || (we && full);
            underflow_reg <= underflow_reg || (re && empty);
        end
    end

    // Storage is never reset; requests arriving with rst/clear are dropped.
    always_ff @(posedge clk) begin
        if (!flush && wr_en) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    generate
        if (AHEAD != 0) begin : g_fwft
            // Head word presented directly; forced to 0 so stale or
            // never-written storage cannot leak out while empty.
            assign dout = empty ? '0 : mem[rd_ptr_reg];
        end else begin : g_regrd
            logic [DWIDTH-1:0] dout_reg;

            always_ff @(posedge clk) begin
                if (flush) begin
                    dout_reg <= '0;
                end else if (rd_en) begin
                    dout_reg <= mem[rd_ptr_reg];
                end
            end

            assign dout = dout_reg;
        end
    endgenerate

`ifdef LDL_SFIFO_PEAK_EN
    logic [AWIDTH:0] peak_reg;

    // Tracks the post-edge occupancy so a fill to DEPTH reports DEPTH.
    always_ff @(posedge clk) begin
        if (flush) begin
            peak_reg <= '0;
        end else if (count_next > peak_reg) begin
            peak_reg <= count_next;
        end
    end

    assign peak = peak_reg;
`else
    assign peak = '0;
`endif

endmodule

// File: tb/tb_ldl_sfifo_flags.sv
// Testbench for ldl_sfifo_flags. Two instances share one stimulus stream:
// u_fa (first-word-fall-through) and u_rr (registered read). A queue-based
// occupancy model is compared against both on every falling edge, and
// directed steps add hand-computed literal expectations.

module tb_ldl_sfifo_flags;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int AF = 14;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          we;
    logic          re;
    logic [DW-1:0] din;
    logic [AW:0]   af_thr;
    logic [AW:0]   ae_thr;

    logic [DW-1:0] dout_fa, dout_rr;
    logic          empty_fa, empty_rr, full_fa, full_rr;
    logic          af_fa, af_rr, ae_fa, ae_rr;
    logic          ovf_fa, ovf_rr, unf_fa, unf_rr;
    logic [AW:0]   count_fa, count_rr, peak_fa, peak_rr;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    ldl_sfifo_flags #(.DWIDTH(DW), .AWIDTH(AW), .AHEAD(1)) u_fa (
        .clk(clk), .rst(rst), .clear(clear), .we(we), .din(din), .re(re),
        .dout(dout_fa), .empty(empty_fa), .full(full_fa),
        .af_thr(af_thr), .ae_thr(ae_thr),
        .almost_full(af_fa), .almost_empty(ae_fa),
        .overflow(ovf_fa), .underflow(unf_fa),
        .count(count_fa), .peak(peak_fa)
    );

    ldl_sfifo_flags #(.DWIDTH(DW), .AWIDTH(AW), .AHEAD(0)) u_rr (
        .clk(clk), .rst(rst), .clear(clear), .we(we), .din(din), .re(re),
        .dout(dout_rr), .empty(empty_rr), .full(full_rr),
        .af_thr(af_thr), .ae_thr(ae_thr),
        .almost_full(af_rr), .almost_empty(ae_rr),
        .overflow(ovf_rr), .underflow(unf_rr),
        .count(count_rr), .peak(peak_rr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] q[$];
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    int            m_peak = 0;
    logic [DW-1:0] m_dout_r = '0;

    always @(posedge clk) begin
        int  sz;
        bit  rd_ok;
        bit  wr_ok;
        sz = q.size();
        if (rst || clear) begin
            q.delete();
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
            m_peak   = 0;
            m_dout_r = '0;
        end else begin
            rd_ok = re && (sz > 0);
            wr_ok = we && (sz < DEPTH);
            if (we && sz == DEPTH) m_ovf = 1'b1;
            if (re && sz == 0)     m_unf = 1'b1;
            if (rd_ok) m_dout_r = q.pop_front();
            if (wr_ok) q.push_back(din);
            if (q.size() > m_peak) m_peak = q.size();
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int            sz;
        logic [DW-1:0] head;
        int            exp_peak;
        if (chk_en) begin
            sz   = q.size();
            head = (sz > 0) ? q[0] : '0;
`ifdef LDL_SFIFO_PEAK_EN
            exp_peak = m_peak;
`else
            exp_peak = 0;
`endif
            check("count_fa",  32'(count_fa), 32'(sz));
            check("count_rr",  32'(count_rr), 32'(sz));
            check("empty_fa",  32'(empty_fa), 32'(sz == 0));
            check("empty_rr",  32'(empty_rr), 32'(sz == 0));
            check("full_fa",   32'(full_fa),  32'(sz == DEPTH));
            check("full_rr",   32'(full_rr),  32'(sz == DEPTH));
            check("afull_fa",  32'(af_fa),    32'(sz >= AF));
            check("afull_rr",  32'(af_rr),    32'(sz >= AF));
            check("aempty_fa", 32'(ae_fa),    32'(sz <= AE));
            check("aempty_rr", 32'(ae_rr),    32'(sz <= AE));
            check("ovf_fa",    32'(ovf_fa),   32'(m_ovf));
            check("ovf_rr",    32'(ovf_rr),   32'(m_ovf));
            check("unf_fa",    32'(unf_fa),   32'(m_unf));
            check("unf_rr",    32'(unf_rr),   32'(m_unf));
            check("dout_fa",   32'(dout_fa),  32'(head));
            check("dout_rr",   32'(dout_rr),  32'(m_dout_r));
            check("peak_fa",   32'(peak_fa),  32'(exp_peak));
            check("peak_rr",   32'(peak_rr),  32'(exp_peak));
        end
    end

    // ---------------- stimulus ----------------
    // Drive one cycle's inputs, let the edge consume them, return at edge+1.
    task automatic drive(input logic r, input logic c, input logic w, input logic rd, input logic [DW-1:0] d);
        rst = r; clear = c; we = w; re = rd; din = d;
        @(posedge clk);
        #1;
        $display("txn rst=%b clr=%b we=%b re=%b din=%h -> count=%0d dout_fa=%h dout_rr=%h ovf=%b unf=%b",
                 r, c, w, rd, d, count_fa, dout_fa, dout_rr, ovf_fa, unf_fa);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; we = 1'b0; re = 1'b0; din = '0;
        af_thr = 5'(AF);
        ae_thr = 5'(AE);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // Reset state.
        check("rst_count", 32'(count_fa), 32'd0);
        check("rst_empty", 32'(empty_rr), 32'd1);
        check("rst_ae",    32'(ae_fa),    32'd1);
        check("rst_af",    32'(af_fa),    32'd0);
        check("rst_dout_rr", 32'(dout_rr), 32'h00);

        // Fill 0xA1..0xB0.
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'hA1 + i));
            check("fill_count", 32'(count_fa), 32'(i + 1));
            check("fill_af",    32'(af_rr),    32'((i + 1) >= 14));
            check("fill_ae",    32'(ae_fa),    32'((i + 1) <= 2));
        end
        check("fill_full", 32'(full_fa), 32'd1);
        check("fill_ovf",  32'(ovf_fa),  32'd0);

        // Overfill.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'hEE);
        check("ovfl_count", 32'(count_rr), 32'd16);
        check("ovfl_flag",  32'(ovf_rr),   32'd1);

        // Drain; registered-read data lags by one cycle.
        for (int i = 0; i < 16; i++) begin
            check("drain_fa", 32'(dout_fa), 32'(8'hA1 + i));
            drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
            check("drain_rr", 32'(dout_rr), 32'(8'hA1 + i));
        end
        check("drain_ovf_sticky", 32'(ovf_fa), 32'd1);

        // Underflow.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("unf_flag",    32'(unf_fa),   32'd1);
        check("unf_count",   32'(count_fa), 32'd0);
        check("unf_dout_fa", 32'(dout_fa),  32'h00);
        check("unf_dout_rr", 32'(dout_rr),  32'hB0);

        // we+re at full.
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h55);
        check("wr_at_full_count", 32'(count_fa), 32'd15);
        check("wr_at_full_dout_rr", 32'(dout_rr), 32'h10);
        for (int i = 0; i < 15; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("drained15", 32'(dout_rr), 32'h1F);

        // we+re at empty.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h66);
        check("wr_at_empty_count", 32'(count_rr), 32'd1);
        check("wr_at_empty_unf",   32'(unf_rr),   32'd1);
        check("wr_at_empty_fa",    32'(dout_fa),  32'h66);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check("wr_at_empty_rr",    32'(dout_rr),  32'h66);

        // Wrap: hold count at 5 with 40 cycles of we+re.
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
        for (int i = 0; i < 40; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 8'(8'h30 + i));
        check("wrap_count", 32'(count_fa), 32'd5);
        check("wrap_head",  32'(dout_fa),  32'h53);
        check("wrap_rr",    32'(dout_rr),  32'h52);

        // Flush at count 9 with a concurrent write.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
        check("pre_flush_count", 32'(count_fa), 32'd9);
`ifdef LDL_SFIFO_PEAK_EN
        check("pre_flush_peak", 32'(peak_fa), 32'd16);
`endif
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h77);
        check("flush_count",   32'(count_fa), 32'd0);
        check("flush_empty",   32'(empty_rr), 32'd1);
        check("flush_ovf",     32'(ovf_fa),   32'd0);
        check("flush_unf",     32'(unf_rr),   32'd0);
        check("flush_peak",    32'(peak_fa),  32'd0);
        check("flush_dout_rr", 32'(dout_rr),  32'h00);

        // Refill and read back.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 8'(8'hC1 + i));
        for (int i = 0; i < 3; i++) begin
            check("refill_fa", 32'(dout_fa), 32'(8'hC1 + i));
            drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
            check("refill_rr", 32'(dout_rr), 32'(8'hC1 + i));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("final_empty", 32'(empty_fa), 32'd1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ldl_sfifo_flags.md
Name: ldl_sfifo_flags

Overview:
Parametrised synchronous FIFO. It is the next generation of the team's single-clock sync FIFO.
- Keeps the selectable read mode: first-word-fall-through or registered read.
- Adds runtime-programmable almost-full and almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush.
- Sits between same-clock producer/consumer datapaths as the standard buffering primitive.

Parameters:
- DWIDTH, 8, data width in bits.
- AWIDTH, 4, address width; DEPTH = 2**AWIDTH entries.
- AHEAD, 1, read mode. 1 = first-word-fall-through. 0 = registered read, data one cycle after re.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous reset, active-high.
- clear  input  1  synchronous flush; same effect as rst on FIFO state, memory contents not cleared.
- we  input  1  write request.
- din  input  DWIDTH  write data.
- re  input  1  read request.
- dout  output  DWIDTH  read data.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- af_thr  input  AWIDTH+1  almost-full threshold.
- ae_thr  input  AWIDTH+1  almost-empty threshold.
- almost_full  output  1  count >= af_thr.
- almost_empty  output  1  count <= ae_thr.
- overflow  output  1  sticky: write attempted while full.
- underflow  output  1  sticky: read attempted while empty.
- count  output  AWIDTH+1  current occupancy, 0..DEPTH.
- peak  output  AWIDTH+1  high-water mark (optional feature).

Behaviour:
- Write accepted iff we && !full. Read accepted iff re && !empty. Acceptance is evaluated on registered state at the clock edge.
- Write and read are independent in the same cycle.
- Full + we + re: read accepted, write rejected, overflow set, count becomes DEPTH-1.
- Empty + we + re: write accepted, read rejected, underflow set, count becomes 1.
- Non-boundary we+re: both accepted, count unchanged.
- wr_ptr and rd_ptr are AWIDTH bits and wrap modulo DEPTH. count is a registered (AWIDTH+1)-bit value, +1 per accepted write, -1 per accepted read.
- AHEAD=1:
  - dout = mem[rd_ptr] combinationally when !empty, else 0.
  - A word written at edge N is visible on dout after edge N (empty deasserts the same edge).
  - Accepted re advances to the next word at the following edge.
- AHEAD=0:
  - dout is a register loaded with mem[rd_ptr] on an accepted read; visible the cycle after the re edge.
  - dout holds its value otherwise, including while empty.
- empty, full, almost_full, almost_empty are combinational from registered count.
  - almost_full with af_thr == 0 is constant 1.
  - Thresholds above DEPTH never assert almost_full.
- overflow/underflow: set on the edge of the rejected request; held until rst or clear.
- Priority order: rst > clear > we/re.
  - rst or clear: pointers = 0, count = 0, overflow = underflow = 0, registered dout = 0, peak = 0.
  - we/re ignored in that cycle, including when rst or clear arrives mid-burst.
- Reset values: empty=1, full=0, count=0, overflow=0, underflow=0, dout=0, peak=0. almost_empty=1 for any ae_thr; almost_full = (af_thr==0).
- Memory is not reset; unread contents are never visible on dout.

Optional Feature:
- Macro: LDL_SFIFO_PEAK_EN.
- Defined: peak is a register updated to count_next whenever count_next > peak, so it tracks maximum occupancy since the last rst/clear. Reaching DEPTH is reported as DEPTH.
- Undefined: peak port is tied to 0 and no register is built.

Test Plan (DWIDTH=8, AWIDTH=4, af_thr=14, ae_thr=2, both AHEAD values):
- Fill: write 0xA1..0xB0 (16 words) -> count 1..16. almost_empty deasserts at count 3, almost_full asserts at count 14, full at 16. Overflow stays 0.
- Overfill: one extra we at full -> count stays 16, overflow=1 and sticky. Drain returns 0xA1..0xB0 in order; AHEAD=0 data lags re by one cycle.
- Underflow: re at empty -> underflow=1, count 0. AHEAD=1: dout=0. AHEAD=0: dout holds the last value 0xB0.
- Boundary simultaneity: we+re at full -> count 15, overflow=1. we+re at empty -> count 1, underflow=1, written word readable next.
- Wrap: 40 cycles of continuous we+re at count 5 -> count stays 5, data order preserved across pointer wrap.
- Flush: assert clear at count 9 with we=1 -> next cycle count=0, empty=1, flags 0, peak=0. Refill and read back correctly. With LDL_SFIFO_PEAK_EN, peak=16 before the flush.
